// File: rtl/serial_link_pkg.sv
// serial_link_pkg: shared FSM state types and 8N1 frame constants
package serial_link_pkg;
  localparam int DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL = 1'b1;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with registered occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && count != (AW+1)'(DEPTH);
  assign do_pop = pop && count != '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/serial_link_bridge.sv
// serial_link_bridge: 8N1 UART bridge between processor serial MMIO and a serial line
module serial_link_bridge
  import serial_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] proc_data_in,
  input  logic       proc_wren_in,
  output logic       proc_ready_out,
  output logic [7:0] proc_data_out,
  output logic       proc_valid_out,
  input  logic       proc_rden_in,
  input  logic       uart_rx_in,
  output logic       uart_tx_out,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  logic [AW:0] tx_count, rx_count;
  logic [DATA_BITS-1:0] tx_head, rx_head, tx_shift, rx_shift;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [2:0] tx_bit, rx_bit;
  logic [1:0] rx_sync;
  logic rx_s, tx_push, tx_pop, rx_push, rx_pop, rx_full;
  tx_state_t tx_state;
  rx_state_t rx_state;
  assign proc_ready_out = tx_count != FULL;
  assign proc_valid_out = rx_count != '0;
  assign proc_data_out = proc_valid_out ? rx_head : 8'h00;
  assign rx_full = rx_count == FULL;
  assign rx_s = rx_sync[1];
  assign tx_push = proc_wren_in && proc_ready_out && !reset;
  assign tx_pop = tx_count != '0 && (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_cnt == '0));
  assign rx_push = rx_state == RX_STOP && rx_cnt == '0 && rx_s == STOP_LVL;
  assign rx_pop = proc_rden_in && proc_valid_out && !reset;
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) tx_fifo (
    .clk(clock), .rst(reset), .push(tx_push), .pop(tx_pop),
    .din(proc_data_in), .dout(tx_head), .count(tx_count)
  );
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) rx_fifo (
    .clk(clock), .rst(reset), .push(rx_push), .pop(rx_pop),
    .din(rx_shift), .dout(rx_head), .count(rx_count)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt <= '0;
      tx_shift <= '0;
      tx_bit <= '0;
      uart_tx_out <= STOP_LVL;
    end else begin
      uart_tx_out <= tx_state == TX_START ? START_LVL : tx_state == TX_DATA ? tx_shift[0] : STOP_LVL;
      case (tx_state)
        TX_IDLE: if (tx_pop) begin
          tx_state <= TX_START;
          tx_shift <= tx_head;
          tx_cnt <= BIT_RELOAD;
        end
        TX_START: if (tx_cnt == '0) begin
          tx_state <= TX_DATA;
          tx_cnt <= BIT_RELOAD;
          tx_bit <= '0;
        end else tx_cnt <= tx_cnt - CW'(1);
        TX_DATA: if (tx_cnt == '0) begin
          tx_state <= tx_bit == LAST_BIT ? TX_STOP : TX_DATA;
          tx_cnt <= BIT_RELOAD;
          tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
          tx_bit <= tx_bit == LAST_BIT ? 3'd0 : tx_bit + 3'd1;
        end else tx_cnt <= tx_cnt - CW'(1);
        TX_STOP: if (tx_cnt == '0) begin
          tx_state <= tx_pop ? TX_START : TX_IDLE;
          tx_shift <= tx_head;
          tx_cnt <= BIT_RELOAD;
        end else tx_cnt <= tx_cnt - CW'(1);
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_sync <= 2'b11;
      rx_state <= RX_IDLE;
      rx_cnt <= '0;
      rx_shift <= '0;
      rx_bit <= '0;
      rx_overrun_out <= 1'b0;
      rx_frame_err_out <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx_in};
      case (rx_state)
        RX_IDLE: if (rx_s == START_LVL) begin
          rx_state <= RX_START;
          rx_cnt <= HALF_RELOAD;
        end
        RX_START: if (rx_cnt == '0) begin
          rx_state <= rx_s == START_LVL ? RX_DATA : RX_IDLE;
          rx_cnt <= BIT_RELOAD;
          rx_bit <= '0;
        end else rx_cnt <= rx_cnt - CW'(1);
        RX_DATA: if (rx_cnt == '0) begin
          rx_state <= rx_bit == LAST_BIT ? RX_STOP : RX_DATA;
          rx_cnt <= BIT_RELOAD;
          rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
          rx_bit <= rx_bit == LAST_BIT ? 3'd0 : rx_bit + 3'd1;
        end else rx_cnt <= rx_cnt - CW'(1);
        RX_STOP: if (rx_cnt == '0) begin
          rx_state <= RX_IDLE;
          rx_overrun_out <= rx_overrun_out | (rx_push && rx_full);
          rx_frame_err_out <= rx_frame_err_out | (rx_s != STOP_LVL);
        end else rx_cnt <= rx_cnt - CW'(1);
      endcase
    end
  end
endmodule

// File: tb/tb_serial_link_bridge.sv
// tb_serial_link_bridge: model-checked directed bench for serial_link_bridge
module tb_serial_link_bridge;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic proc_wren_in = 1'b0;
  logic proc_rden_in = 1'b0;
  logic uart_rx_in = 1'b1;
  logic [7:0] proc_data_in = 8'h00;
  logic proc_ready_out, proc_valid_out, uart_tx_out, rx_overrun_out, rx_frame_err_out;
  logic [7:0] proc_data_out;
  always #5 clock = ~clock;
  serial_link_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .proc_data_in(proc_data_in), .proc_wren_in(proc_wren_in), .proc_ready_out(proc_ready_out),
    .proc_data_out(proc_data_out), .proc_valid_out(proc_valid_out), .proc_rden_in(proc_rden_in),
    .uart_rx_in(uart_rx_in), .uart_tx_out(uart_tx_out),
    .rx_overrun_out(rx_overrun_out), .rx_frame_err_out(rx_frame_err_out)
  );
  int cyc = 0;
  int tx_st[$];
  logic [7:0] tx_by[$];
  int last_end = 0;
  logic [7:0] rx_q[$];
  int arr_c[$];
  logic [7:0] arr_d[$];
  logic arr_ok[$];
  logic m_ovr = 1'b0, m_ferr = 1'b0;
  logic exp_line = 1'b1, exp_ready = 1'b1, exp_valid = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic note_v = 1'b0, note_ok = 1'b1;
  logic [7:0] note_d = 8'h00;
  int occ, k, n, st;
  logic [7:0] b;
  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      tx_st.delete();
      tx_by.delete();
      last_end = 0;
      rx_q.delete();
      arr_c.delete();
      arr_d.delete();
      arr_ok.delete();
      m_ovr = 1'b0;
      m_ferr = 1'b0;
    end else begin
      occ = 0;
      foreach (tx_st[i]) if (tx_st[i] > cyc) occ++;
      if (proc_wren_in && occ < DEPTH) begin
        st = (cyc + 2 > last_end) ? cyc + 2 : last_end;
        tx_st.push_back(st);
        tx_by.push_back(proc_data_in);
        last_end = st + FRAME;
      end
      if (note_v) begin
        arr_c.push_back(cyc + 2 + CPB / 2 + 9 * CPB);
        arr_d.push_back(note_d);
        arr_ok.push_back(note_ok);
      end
      n = rx_q.size();
      if (proc_rden_in && n > 0) void'(rx_q.pop_front());
      if (arr_c.size() > 0 && arr_c[0] == cyc) begin
        if (!arr_ok[0]) m_ferr = 1'b1;
        else if (n < DEPTH) rx_q.push_back(arr_d[0]);
        else m_ovr = 1'b1;
        void'(arr_c.pop_front());
        void'(arr_d.pop_front());
        void'(arr_ok.pop_front());
      end
    end
    while (tx_st.size() > 0 && cyc >= tx_st[0] + FRAME) begin
      void'(tx_st.pop_front());
      void'(tx_by.pop_front());
    end
    exp_line = 1'b1;
    if (tx_st.size() > 0 && cyc >= tx_st[0]) begin
      k = (cyc - tx_st[0]) / CPB;
      b = tx_by[0];
      exp_line = k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
    end
    occ = 0;
    foreach (tx_st[i]) if (tx_st[i] > cyc + 1) occ++;
    exp_ready = occ < DEPTH;
    exp_valid = rx_q.size() > 0;
    exp_data = exp_valid ? rx_q[0] : 8'h00;
  end
  int tests = 0, fails = 0, t = 0, w, s;
  logic tx_log [0:4095];
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h (tick %0d)", name, act, exp, t);
    end
  endtask
  task automatic tick();
    @(negedge clock);
    t++;
    tx_log[t] = uart_tx_out;
    chk("tx_line", 8'(uart_tx_out), 8'(exp_line));
    chk("ready", 8'(proc_ready_out), 8'(exp_ready));
    chk("valid", 8'(proc_valid_out), 8'(exp_valid));
    chk("rx_data", proc_data_out, exp_data);
    chk("overrun", 8'(rx_overrun_out), 8'(m_ovr));
    chk("frame_err", 8'(rx_frame_err_out), 8'(m_ferr));
  endtask
  function automatic int find_low(input int from);
    for (int i = from; i <= t; i++) if (tx_log[i] == 1'b0) return i;
    return -1;
  endfunction
  function automatic logic [7:0] decode(input int at);
    logic [7:0] r = 8'h00;
    if (at < 0 || at + 2 + 8 * CPB > t) return 8'hxx;
    for (int i = 0; i < 8; i++) r[i] = tx_log[at + CPB / 2 + CPB * (i + 1)];
    return r;
  endfunction
  task automatic send_rx(input logic [7:0] d, input logic stop);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    note_d = d;
    note_ok = stop;
    note_v = 1'b1;
    for (int i = 0; i < 10; i++) begin
      uart_rx_in = fr[i];
      repeat (CPB) begin
        tick();
        note_v = 1'b0;
      end
    end
    uart_rx_in = 1'b1;
  endtask
  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_line", 8'(uart_tx_out), 8'h01);
    chk("rst_ready", 8'(proc_ready_out), 8'h01);
    chk("rst_valid", 8'(proc_valid_out), 8'h00);
    chk("rst_data", proc_data_out, 8'h00);
    chk("rst_flags", {6'd0, rx_overrun_out, rx_frame_err_out}, 8'h00);
    proc_data_in = 8'h41;
    proc_wren_in = 1'b1;
    tick();
    proc_wren_in = 1'b0;
    w = t;
    repeat (46) tick();
    s = find_low(w);
    chk("tx41_latency", 8'(s - w), 8'd2);
    chk("tx41_start_len", 8'({tx_log[s+3], tx_log[s+4]}), 8'h01);
    chk("tx41_byte", decode(s), 8'h41);
    chk("tx41_stop", 8'(tx_log[s+38]), 8'h01);
    w = t + 1;
    for (int i = 0; i < 6; i++) begin
      proc_data_in = 8'h10 + 8'(i);
      proc_wren_in = 1'b1;
      tick();
      if (i == 4) chk("burst_full_ready", 8'(proc_ready_out), 8'h00);
    end
    proc_wren_in = 1'b0;
    repeat (210) tick();
    s = find_low(w);
    chk("burst_latency", 8'(s - w), 8'd2);
    for (int i = 0; i < 5; i++) chk("burst_byte", decode(s + FRAME * i), 8'h10 + 8'(i));
    chk("burst_no_sixth", 8'(tx_log[s + 5 * FRAME + 2]), 8'h01);
    chk("burst_ready_back", 8'(proc_ready_out), 8'h01);
    send_rx(8'hA5, 1'b1);
    repeat (2) tick();
    chk("rxA5_valid", 8'(proc_valid_out), 8'h01);
    chk("rxA5_data", proc_data_out, 8'hA5);
    proc_rden_in = 1'b1;
    tick();
    proc_rden_in = 1'b0;
    chk("rxA5_popped", 8'(proc_valid_out), 8'h00);
    chk("rxA5_empty_data", proc_data_out, 8'h00);
    uart_rx_in = 1'b0;
    tick();
    uart_rx_in = 1'b1;
    repeat (8) tick();
    chk("glitch_valid", 8'(proc_valid_out), 8'h00);
    chk("glitch_ferr", 8'(rx_frame_err_out), 8'h00);
    send_rx(8'h3C, 1'b0);
    repeat (6) tick();
    chk("badstop_ferr", 8'(rx_frame_err_out), 8'h01);
    chk("badstop_valid", 8'(proc_valid_out), 8'h00);
    for (int i = 0; i < 5; i++) send_rx(8'h01 + 8'(i), 1'b1);
    repeat (4) tick();
    chk("ovr_flag", 8'(rx_overrun_out), 8'h01);
    for (int i = 0; i < 4; i++) begin
      chk("ovr_held", proc_data_out, 8'h01 + 8'(i));
      proc_rden_in = 1'b1;
      tick();
      proc_rden_in = 1'b0;
    end
    chk("ovr_drained", 8'(proc_valid_out), 8'h00);
    send_rx(8'h77, 1'b1);
    repeat (2) tick();
    chk("pre_rst_valid", 8'(proc_valid_out), 8'h01);
    proc_data_in = 8'h5A;
    proc_wren_in = 1'b1;
    tick();
    proc_wren_in = 1'b0;
    repeat (20) tick();
    chk("pre_rst_busy", 8'(find_low(t - 19) >= 0), 8'h01);
    reset = 1'b1;
    proc_wren_in = 1'b1;
    proc_rden_in = 1'b1;
    proc_data_in = 8'hFF;
    tick();
    reset = 1'b0;
    proc_wren_in = 1'b0;
    proc_rden_in = 1'b0;
    chk("midrst_line", 8'(uart_tx_out), 8'h01);
    chk("midrst_ready", 8'(proc_ready_out), 8'h01);
    chk("midrst_valid", 8'(proc_valid_out), 8'h00);
    chk("midrst_data", proc_data_out, 8'h00);
    chk("midrst_flags", {6'd0, rx_overrun_out, rx_frame_err_out}, 8'h00);
    w = t;
    repeat (50) tick();
    chk("midrst_quiet", 8'(find_low(w) < 0), 8'h01);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
